// File: rtl/sc_pointtype_sequencer.sv
// Control sequencer for the point-type register: clear/load strobes, paced
// left/right rotates from the buttons, level tracking, and game-over/win stops.
module sc_pointtype_sequencer #(
  parameter int unsigned TICK_DIV    = 25000000,
  parameter int unsigned LEVEL_WIDTH = 4,
  parameter int unsigned MAX_LEVEL   = 9
) (
  input  logic                   SC_SEQ_CLOCK_50,
  input  logic                   SC_SEQ_RESET_InLow,
  input  logic                   SC_SEQ_start_InLow,
  input  logic                   SC_SEQ_left_InLow,
  input  logic                   SC_SEQ_right_InLow,
  input  logic                   SC_SEQ_collision_InLow,
  input  logic                   SC_SEQ_nest_reached_InLow,
  output logic                   SC_SEQ_clear_OutLow,
  output logic                   SC_SEQ_load0_OutLow,
  output logic                   SC_SEQ_load1_OutLow,
  output logic [1:0]             SC_SEQ_shiftselection_OutBUS,
  output logic [LEVEL_WIDTH-1:0] SC_SEQ_level_OutBUS,
  output logic [2:0]             SC_SEQ_state_OutBUS,
  output logic                   SC_SEQ_gameover_OutHigh,
  output logic                   SC_SEQ_win_OutHigh
);

  localparam int unsigned            PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]          TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX = LEVEL_WIDTH'(MAX_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_LOAD0    = 3'd2,
    S_RUN      = 3'd3,
    S_SHIFT    = 3'd4,
    S_LOAD1    = 3'd5,
    S_GAMEOVER = 3'd6,
    S_WIN      = 3'd7
  } state_t;

  state_t                 r_state, w_state_next;
  logic [PW-1:0]          r_presc, w_presc_next;
  logic [LEVEL_WIDTH-1:0] r_level, w_level_next;
  logic                   r_dir_right, w_dir_right_next;
  logic                   w_tick;
  logic                   w_one_button;
  logic                   w_in_play, w_next_in_play;

  assign w_tick         = (r_presc == TICK_LAST);
  assign w_one_button   = SC_SEQ_left_InLow ^ SC_SEQ_right_InLow;
  assign w_in_play      = (r_state == S_RUN) || (r_state == S_SHIFT);
  assign w_next_in_play = (w_state_next == S_RUN) || (w_state_next == S_SHIFT);

  always_ff @(posedge SC_SEQ_CLOCK_50 or negedge SC_SEQ_RESET_InLow) begin
    if (!SC_SEQ_RESET_InLow) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_level     <= '0;
      r_dir_right <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_presc     <= w_presc_next;
      r_level     <= w_level_next;
      r_dir_right <= w_dir_right_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_level_next     = r_level;
    w_dir_right_next = r_dir_right;
    case (r_state)
      S_IDLE: begin
        if (!SC_SEQ_start_InLow) w_state_next = S_CLEAR;
      end
      S_CLEAR: begin
        w_state_next = S_LOAD0;
        w_level_next = '0;
      end
      S_LOAD0: begin
        w_state_next = S_RUN;
      end
      S_RUN, S_SHIFT: begin
        // SHIFT lasts one cycle, but collision/nest still pre-empt the return to RUN
        w_state_next = S_RUN;
        if (!SC_SEQ_collision_InLow) begin
          w_state_next = S_GAMEOVER;
        end else if (!SC_SEQ_nest_reached_InLow) begin
          if (r_level == LEVEL_MAX) begin
            w_state_next = S_WIN;
          end else begin
            w_level_next = r_level + LEVEL_WIDTH'(1);
            w_state_next = S_LOAD1;
          end
        end else if ((r_state == S_RUN) && w_tick && w_one_button) begin
          w_state_next     = S_SHIFT;
          w_dir_right_next = ~SC_SEQ_right_InLow;
        end
      end
      S_LOAD1: begin
        w_state_next = S_RUN;
      end
      S_GAMEOVER, S_WIN: begin
        if (!SC_SEQ_start_InLow) begin
          w_state_next = S_CLEAR;
          w_level_next = '0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Prescaler only runs while play continues; any other state pins it at zero
    w_presc_next = '0;
    if (w_in_play && w_next_in_play) begin
      w_presc_next = w_tick ? '0 : r_presc + PW'(1);
    end
  end

  always_comb begin
    SC_SEQ_clear_OutLow          = (r_state != S_CLEAR);
    SC_SEQ_load0_OutLow          = (r_state != S_LOAD0);
    SC_SEQ_load1_OutLow          = (r_state != S_LOAD1);
    SC_SEQ_shiftselection_OutBUS = 2'b00;
    if (r_state == S_SHIFT) begin
      SC_SEQ_shiftselection_OutBUS = r_dir_right ? 2'b10 : 2'b01;
    end
    SC_SEQ_level_OutBUS     = r_level;
    SC_SEQ_state_OutBUS     = r_state;
    SC_SEQ_gameover_OutHigh = (r_state == S_GAMEOVER);
    SC_SEQ_win_OutHigh      = (r_state == S_WIN);
  end

endmodule

// File: tb/tb_sc_pointtype_sequencer.sv
// Directed and randomized bench for sc_pointtype_sequencer against a
// cycle-count reference model of the game flow.
module tb_sc_pointtype_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start, i_left, i_right, i_coll, i_nest;
  logic       o_clear, o_load0, o_load1, o_gameover, o_win;
  logic [1:0] o_shift;
  logic [3:0] o_level;
  logic [2:0] o_state;

  int unsigned errors = 0;
  int unsigned checks = 0;

  int  m_state;
  int  m_level;
  int  m_cyc;
  bit  m_dir_right;

  always #5 clk = ~clk;

  sc_pointtype_sequencer #(
    .TICK_DIV   (4),
    .LEVEL_WIDTH(4),
    .MAX_LEVEL  (9)
  ) dut (
    .SC_SEQ_CLOCK_50             (clk),
    .SC_SEQ_RESET_InLow          (rst_n),
    .SC_SEQ_start_InLow          (i_start),
    .SC_SEQ_left_InLow           (i_left),
    .SC_SEQ_right_InLow          (i_right),
    .SC_SEQ_collision_InLow      (i_coll),
    .SC_SEQ_nest_reached_InLow   (i_nest),
    .SC_SEQ_clear_OutLow         (o_clear),
    .SC_SEQ_load0_OutLow         (o_load0),
    .SC_SEQ_load1_OutLow         (o_load1),
    .SC_SEQ_shiftselection_OutBUS(o_shift),
    .SC_SEQ_level_OutBUS         (o_level),
    .SC_SEQ_state_OutBUS         (o_state),
    .SC_SEQ_gameover_OutHigh     (o_gameover),
    .SC_SEQ_win_OutHigh          (o_win)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {clear_n, load0_n, load1_n, shiftsel[1:0], gameover, win}
  function automatic logic [6:0] exp_outs();
    logic [1:0] sh;
    sh = 2'b00;
    if (m_state == 4) sh = m_dir_right ? 2'b10 : 2'b01;
    return {m_state != 1, m_state != 2, m_state != 5, sh, m_state == 6, m_state == 7};
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_state"}, 16'(o_state), 16'(m_state));
    chk({tag, "_level"}, 16'(o_level), 16'(m_level));
    chk({tag, "_outs"},
        16'({o_clear, o_load0, o_load1, o_shift, o_gameover, o_win}), 16'(exp_outs()));
  endtask

  task automatic model_reset();
    m_state     = 0;
    m_level     = 0;
    m_cyc       = 0;
    m_dir_right = 1'b0;
  endtask

  task automatic step(input string tag, input bit st, input bit l, input bit r,
                      input bit co, input bit ne);
    int prev;
    @(negedge clk);
    i_start = st; i_left = l; i_right = r; i_coll = co; i_nest = ne;
    prev = m_state;
    case (prev)
      0: if (!st) m_state = 1;
      1: begin m_state = 2; m_level = 0; end
      2: begin m_state = 3; m_cyc = 0; end
      3, 4: begin
        if (!co) m_state = 6;
        else if (!ne) begin
          if (m_level == 9) m_state = 7;
          else begin m_level = m_level + 1; m_state = 5; end
        end else if (prev == 3 && (m_cyc % 4) == 3 && (l != r)) begin
          m_state = 4; m_dir_right = !r; m_cyc++;
        end else begin
          m_state = 3; m_cyc++;
        end
      end
      5: begin m_state = 3; m_cyc = 0; end
      default: if (!st) begin m_state = 1; m_level = 0; end
    endcase
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_step(input string tag);
    step(tag, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic start_game();
    step("start", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t1_clear_strobe", 16'(o_clear), 16'd0);
    idle_step("clear");
    chk("t1_load0_strobe", 16'(o_load0), 16'd0);
    chk("t1_level_zero", 16'(o_level), 16'd0);
    idle_step("load0");
    chk("t1_run_state", 16'(o_state), 16'd3);
  endtask

  initial begin
    int shifts;
    bit reached;
    i_start = 1'b1; i_left = 1'b1; i_right = 1'b1; i_coll = 1'b1; i_nest = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) idle_step("idle");

    // 1: start sequence
    start_game();

    // 2: paced rotates
    shifts = 0;
    for (int i = 0; i < 12; i++) begin
      step("left", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      if (o_shift == 2'b01) shifts++;
    end
    chk("t2_left_count", 16'(shifts), 16'd3);
    for (int i = 0; i < 12; i++) step("right", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step("both", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("t2_both_hold", 16'(o_shift), 16'd0);
    end
    for (int i = 0; i < 6; i++) idle_step("none");

    // 3: level advance, then climb to the win
    for (int i = 0; i < 2; i++) begin
      step("nest", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      idle_step("load1");
    end
    step("nest2", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_level3", 16'(o_level), 16'd3);
    chk("t3_load1_strobe", 16'(o_load1), 16'd0);
    idle_step("load1b");
    chk("t3_back_run", 16'(o_state), 16'd3);
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      step("climb", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      if (m_state == 7) reached = 1'b1;
      else idle_step("climb_load1");
    end
    chk("t3_win_reached", 16'(reached), 16'd1);
    chk("t3_win_flag", 16'(o_win), 16'd1);
    chk("t3_win_level", 16'(o_level), 16'd9);
    idle_step("win_hold");

    // 4: collision beats nest
    start_game();
    for (int i = 0; i < 2; i++) begin
      step("nest4", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      idle_step("load1_4");
    end
    step("coll_nest", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_state", 16'(o_state), 16'd6);
    chk("t4_gameover", 16'(o_gameover), 16'd1);
    chk("t4_level", 16'(o_level), 16'd2);
    step("start_ignored_hold", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // 5: restart from GAMEOVER
    start_game();

    // randomized play including restarts
    for (int i = 0; i < 600; i++) begin
      step("rand",
           ($urandom_range(3) != 0),
           $urandom_range(1) == 1,
           $urandom_range(1) == 1,
           ($urandom_range(59) != 0),
           ($urandom_range(19) != 0));
    end

    // reset while in SHIFT
    if (m_state > 5 || m_state < 3) start_game();
    step("pre_nest", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 12 && !reached; i++) begin
      step("to_shift", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      if (m_state == 4) reached = 1'b1;
    end
    chk("t5_shift_reached", 16'(reached), 16'd1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("post_reset", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
